// File: rtl/seg7_bcd_display.sv
// N-digit BCD up/down counter with a time-multiplexed 7-segment scan driver.
// Each digit is its own cell in a ripple carry/borrow chain. A free-running slot
// counter drives the scan. Its top bits split each slot into phases, and the first
// and last phase of every slot are kept dark so adjacent anodes never overlap.

module seg7_bcd_digit (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step_in,
  input  logic       up,
  output logic [3:0] digit,
  output logic       step_out
);
  logic [3:0] digit_q, digit_d;

  // next digit: clamped load wins, else a BCD step that ripples out on 9->0 / 0->9
  always_comb begin
    digit_d  = digit_q;
    step_out = 1'b0;
    if (load) begin
      digit_d = (load_nib > 4'd9) ? 4'd9 : load_nib;
    end else if (step_in) begin
      if (up) begin
        if (digit_q == 4'd9) begin
          digit_d  = 4'd0;
          step_out = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_d  = 4'd9;
          step_out = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  // digit register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) digit_q <= 4'd0;
    else         digit_q <= digit_d;
  end

  assign digit = digit_q;
endmodule

module seg7_bcd_display #(
  parameter int NDIGITS      = 4,
  parameter int TICK_LOG2    = 21,
  parameter int REFRESH_LOG2 = 14,
  parameter int BLANK_LOG2   = 4,
  parameter int LZB          = 0,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  input  logic [NDIGITS-1:0]     dp,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   wrap,
  output logic [7:0]             seg,
  output logic [NDIGITS-1:0]     an
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [7:0]         SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NDIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

  logic [TICK_LOG2-1:0]    tick_cnt_q, tick_cnt_d;
  logic [REFRESH_LOG2-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic [7:0]              seg_q, seg_d;
  logic [NDIGITS-1:0]      an_q, an_d;

  logic                    tick;
  logic [NDIGITS:0]        step;
  logic [NDIGITS-1:0][3:0] digits;
  logic [BLANK_LOG2-1:0]   phase;
  logic                    lit;
  logic [NDIGITS-1:0]      lz_blank;
  logic                    zero_hi;
  logic [3:0]              cur_dig;
  logic                    cur_dp, cur_blank;
  logic [7:0]              seg_raw;
  logic [NDIGITS-1:0]      an_raw;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign tick    = &tick_cnt_q;
  // load takes priority, so it also suppresses the step (and therefore wrap)
  assign step[0] = tick & en & ~load;

  genvar g;
  generate
    for (g = 0; g < NDIGITS; g++) begin : g_dig
      seg7_bcd_digit u_dig (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .load_nib (load_val[4*g +: 4]),
        .step_in  (step[g]),
        .up       (up),
        .digit    (digits[g]),
        .step_out (step[g+1])
      );
    end
  endgenerate

  // free-running tick and slot counters, digit index advances at end of slot
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_LOG2'(1);
    slot_cnt_d = slot_cnt_q + REFRESH_LOG2'(1);
    idx_d      = idx_q;
    if (&slot_cnt_q)
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
    wrap_d = step[NDIGITS];
  end

  // leading-zero map: a digit blanks if it and everything above it is zero
  always_comb begin
    lz_blank = '0;
    zero_hi  = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_hi     = zero_hi & (digits[i] == 4'd0);
      lz_blank[i] = (LZB != 0) && (i != 0) && zero_hi;
    end
  end

  // select the scanned digit and build the registered seg/an image
  always_comb begin
    phase     = slot_cnt_q[REFRESH_LOG2-1 -: BLANK_LOG2];
    lit       = (|phase) && !(&phase);
    cur_dig   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig   = digits[i];
        cur_dp    = dp[i];
        cur_blank = lz_blank[i];
        an_raw[i] = lit;
      end
    end
    seg_raw = lit ? {cur_dp, cur_blank ? 7'h00 : glyph(cur_dig)} : 8'h00;
    seg_d   = SEG_OFF ^ seg_raw;
    an_d    = AN_OFF ^ an_raw;
  end

  // state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
      slot_cnt_q <= '0;
      idx_q      <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign value = digits;
  assign wrap  = wrap_q;
  assign seg   = seg_q;
  assign an    = an_q;
endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed bench: three instances (main, leading-zero blanking, 3-digit) run off a
// shared clock. Count behaviour is table-driven; tick timing, load/tick
// collision, scan pattern and async reset are hand sequences.

module tb_seg7_bcd_display;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b1, up = 1'b1, load = 1'b0, load_l = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [15:0] value, value_l;
  logic [11:0] value3;
  logic        wrap, wrap_l, wrap3;
  logic [7:0]  seg, seg_l, seg3;
  logic [3:0]  an, an_l;
  logic [2:0]  an3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg7_bcd_display #(.NDIGITS(4), .TICK_LOG2(3), .REFRESH_LOG2(4), .BLANK_LOG2(2),
                     .LZB(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load), .load_val(load_val),
    .dp(dp), .value(value), .wrap(wrap), .seg(seg), .an(an));

  seg7_bcd_display #(.NDIGITS(4), .TICK_LOG2(3), .REFRESH_LOG2(4), .BLANK_LOG2(2),
                     .LZB(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut_lzb (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load_l), .load_val(load_val),
    .dp(dp), .value(value_l), .wrap(wrap_l), .seg(seg_l), .an(an_l));

  seg7_bcd_display #(.NDIGITS(3), .TICK_LOG2(3), .REFRESH_LOG2(4), .BLANK_LOG2(2),
                     .LZB(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut3 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load), .load_val(load_val[11:0]),
    .dp(dp[2:0]), .value(value3), .wrap(wrap3), .seg(seg3), .an(an3));

  // posedges since reset release
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    bit          ld;
    logic [15:0] ld_val;
    bit          en;
    bit          up;
    int          nticks;
    logic [15:0] exp_val;
    bit          exp_wrap;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic clk1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // load without colliding with a tick edge
  task automatic do_load(input logic [15:0] v);
    if ((cyc + 1) % 8 == 0) clk1;
    load_val = v;
    load = 1'b1;
    clk1;
    load = 1'b0;
  endtask

  // advance through the next tick edge
  task automatic do_tick;
    int k = 0;
    do begin
      clk1;
      k++;
    end while ((cyc % 8 != 0) && (k < 9));
  endtask

  function automatic logic [6:0] glyph_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F; default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input int idx,
                                         input logic [3:0] dpv, input bit lzb, input bit lit);
    logic [3:0] d;
    bit         blank;
    logic [7:0] raw;
    if (!lit) return 8'hFF;
    d     = v[4*idx +: 4];
    blank = lzb && (idx > 0) && ((v >> (4*idx)) == 16'h0);
    raw   = {dpv[idx], blank ? 7'h00 : glyph_ref(d)};
    return ~raw;
  endfunction

  // one scan sample: seg/an lag the slot state by one cycle
  task automatic scan_check(input logic [3:0] dpv);
    int s, i4, i3;
    bit lit;
    logic [3:0] one4;
    logic [2:0] one3;
    clk1;
    s    = (cyc - 1) % 16;
    i4   = ((cyc - 1) / 16) % 4;
    i3   = ((cyc - 1) / 16) % 3;
    lit  = (s >= 4) && (s <= 11);
    one4 = 4'b0001;
    one3 = 3'b001;
    chk("scan_main", {seg, an},
        {exp_seg(16'h1234, i4, dpv, 1'b0, lit), lit ? ~(one4 << i4) : 4'hF});
    chk("scan_lzb", {seg_l, an_l},
        {exp_seg(16'h0040, i4, dpv, 1'b1, lit), lit ? ~(one4 << i4) : 4'hF});
    chk("scan_an3", {5'b0, an3}, {5'b0, lit ? ~(one3 << i3) : 3'h7});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 16'h0999, 1, 1, 1,  16'h1000, 0};
    vecs[1] = '{1, 16'h9999, 1, 1, 1,  16'h0000, 1};
    vecs[2] = '{1, 16'h0000, 1, 0, 1,  16'h9999, 1};
    vecs[3] = '{1, 16'h1000, 1, 0, 1,  16'h0999, 0};
    vecs[4] = '{0, 16'h0000, 0, 1, 10, 16'h0999, 0};
    vecs[5] = '{1, 16'hA5F3, 1, 1, 0,  16'h9593, 0};
    vecs[6] = '{0, 16'h0000, 1, 1, 1,  16'h9594, 0};
    vecs[7] = '{1, 16'h0019, 1, 1, 2,  16'h0021, 0};
    vecs[8] = '{1, 16'h0100, 1, 0, 1,  16'h0099, 0};

    // reset held 5 cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_value", value, 16'h0000);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_an", an, 4'hF);
    chk("rst_an3", an3, 3'h7);
    resetn = 1'b1;

    // first tick lands on the 8th edge after release
    for (int k = 0; k < 20; k++) begin
      clk1;
      if (value !== 16'h0) break;
    end
    chk("first_tick_cycle", cyc, 8);
    chk("first_tick_value", value, 16'h0001);

    // table-driven count vectors
    foreach (vecs[v]) begin
      en = vecs[v].en;
      up = vecs[v].up;
      if (vecs[v].ld) begin
        do_load(vecs[v].ld_val);
        chk("load_no_wrap", wrap, 1'b0);
      end
      for (int t = 0; t < vecs[v].nticks; t++) do_tick;
      chk($sformatf("vec%0d_value", v), value, vecs[v].exp_val);
      chk($sformatf("vec%0d_wrap", v), wrap, vecs[v].exp_wrap);
      if (vecs[v].exp_wrap) begin
        clk1;
        chk($sformatf("vec%0d_wrap_drop", v), wrap, 1'b0);
      end
    end

    // load and tick on the same edge: load wins, no wrap, tick phase untouched
    en = 1'b1;
    up = 1'b1;
    for (int k = 0; k < 9 && ((cyc + 1) % 8 != 0); k++) clk1;
    load_val = 16'h9999;
    load = 1'b1;
    clk1;
    load = 1'b0;
    chk("load_tick_value", value, 16'h9999);
    chk("load_tick_wrap", wrap, 1'b0);
    do_tick;
    chk("after_load_tick_value", value, 16'h0000);
    chk("after_load_tick_wrap", wrap, 1'b1);

    // scan: hold value steady and walk several full index rounds
    en = 1'b0;
    do_load(16'h1234);
    load_val = 16'h0040;
    load_l = 1'b1;
    clk1;
    load_l = 1'b0;
    chk("lzb_loaded", value_l, 16'h0040);
    dp = 4'b0001;
    for (int c = 0; c < 96; c++) scan_check(dp);
    dp = 4'b1000;
    for (int c = 0; c < 64; c++) scan_check(dp);

    // async reset in the middle of a lit phase
    for (int k = 0; k < 17 && (cyc % 16 != 7); k++) clk1;
    chk("pre_reset_lit", an, 4'b1110 ^ 4'b0000 ^ ((cyc / 16) % 4 == 0 ? 4'h0 : 4'h0) ^
        (((cyc / 16) % 4 == 0) ? 4'h0 : 4'h0) ^ (4'b0001 ^ (4'b0001 << ((cyc / 16) % 4))));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_seg", seg, 8'hFF);
    chk("async_an", an, 4'hF);
    chk("async_value", value, 16'h0000);
    chk("async_lzb_seg", seg_l, 8'hFF);
    chk("async_an3", an3, 3'h7);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
